// File: rtl/subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DATA_WD_DEFAULT = 16;
    localparam int CNT_W_DEFAULT   = $clog2(DATA_WD_DEFAULT);

    function automatic int cnt_width(input int data_wd);
        return $clog2(data_wd);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor with valid/ready handshakes on both sides.
module serial_subtractor
    import subtractor_pkg::*;
#(
    parameter int DATA_WD = DATA_WD_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [DATA_WD-1:0] i_a,
    input  logic [DATA_WD-1:0] i_b,
    input  logic               i_valid,
    output logic               o_ready,
    output logic [DATA_WD:0]   o_diff,
    output logic               o_valid,
    input  logic               i_ready
);

    localparam int CNT_W = cnt_width(DATA_WD);

    state_t             r_state;
    state_t             w_next;
    logic [DATA_WD-1:0] r_a;
    logic [DATA_WD-1:0] r_b;
    logic [DATA_WD-1:0] r_res;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_br;
    logic [DATA_WD:0]   r_diff;
    logic               w_d;
    logic               w_bout;
    logic               w_accept;
    logic               w_last;

    assign o_ready  = (r_state == IDLE) && !i_rst;
    assign o_valid  = (r_state == DONE);
    assign o_diff   = r_diff;
    assign w_accept = i_valid && o_ready;
    assign w_last   = (r_cnt == CNT_W'(DATA_WD - 1));

    full_subtractor u_fs (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_bout)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = RUN;
            RUN:     if (w_last)   w_next = DONE;
            DONE:    if (i_ready)  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: LSB-first subtraction, result filled from the MSB side.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_cnt  <= '0;
            r_br   <= 1'b0;
            r_diff <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a   <= i_a;
                        r_b   <= i_b;
                        r_br  <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    r_a   <= {1'b0, r_a[DATA_WD-1:1]};
                    r_b   <= {1'b0, r_b[DATA_WD-1:1]};
                    r_res <= {w_d, r_res[DATA_WD-1:1]};
                    r_br  <= w_bout;
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Final bit: capture the full result so it holds until the next DONE.
                    if (w_last) begin
                        r_diff <= {w_bout, w_d, r_res[DATA_WD-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed vectors plus a queue-based reference model.
module tb_serial_subtractor;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         i_valid;
    logic         o_ready;
    logic [W:0]   o_diff;
    logic         o_valid;
    logic         i_ready;

    int n_cmp = 0;
    int n_err = 0;

    logic [W:0] q[$];

    serial_subtractor #(.DATA_WD(W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_diff  (o_diff),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: unsigned difference in W+1 bits, one entry per accepted operation.
    always @(posedge clk) begin
        logic [W:0] ref_val;
        if (rst) begin
            q.delete();
        end else begin
            if (o_valid && i_ready && q.size() > 0) void'(q.pop_front());
            if (i_valid && o_ready) begin
                ref_val = {1'b0, i_a} - {1'b0, i_b};
                q.push_back(ref_val);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && o_valid) begin
            if (q.size() == 0) check("spurious_valid", 32'(o_valid), 32'd0);
            else               check("model", 32'(o_diff), 32'(q[0]));
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W:0] exp, input int hold, input bit toggle);
        int t;
        int lat;
        t = 0;
        while (!o_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("ready_before_op", 32'(o_ready), 32'd1);
        i_a     = a;
        i_b     = b;
        i_valid = 1'b1;
        i_ready = (hold == 0);
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 40) begin
            if (toggle) begin
                i_a     = W'($urandom);
                i_b     = W'($urandom);
                i_valid = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        i_valid = 1'b0;
        check("latency", 32'(lat), 32'd16);
        check("result", 32'(o_diff), 32'(exp));
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                check("bp_valid", 32'(o_valid), 32'd1);
                check("bp_ready", 32'(o_ready), 32'd0);
                check("bp_diff", 32'(o_diff), 32'(exp));
            end
            i_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("valid_drop", 32'(o_valid), 32'd0);
        check("ready_back", 32'(o_ready), 32'd1);
        check("diff_hold", 32'(o_diff), 32'(exp));
        i_ready = 1'b0;
    endtask

    initial begin
        int vcnt;
        int t;
        rst     = 1'b1;
        i_a     = '0;
        i_b     = '0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_diff", 32'(o_diff), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(o_ready), 32'd1);

        run_op(16'h1234, 16'h0034, 17'h01200, 0, 0);
        run_op(16'h0000, 16'h0001, 17'h1FFFF, 0, 0);
        run_op(16'h0003, 16'h0005, 17'h1FFFE, 0, 0);
        run_op(16'hFFFF, 16'hFFFF, 17'h00000, 0, 0);
        run_op(16'h8000, 16'h0001, 17'h07FFF, 5, 0);

        // Abandon an operation partway through RUN with an asynchronous reset.
        i_a     = 16'h00F0;
        i_b     = 16'h000F;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", 32'(o_valid), 32'd0);
        check("midrst_diff", 32'(o_diff), 32'd0);
        check("midrst_ready", 32'(o_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        vcnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (o_valid) vcnt++;
        end
        check("no_result_after_rst", 32'(vcnt), 32'd0);
        run_op(16'h0005, 16'h0003, 17'h00002, 0, 0);

        run_op(16'hA5A5, 16'h5A5A, 17'h04B4B, 0, 1);
        run_op(16'h0001, 16'hFFFF, 17'h10002, 0, 1);

        // Back-to-back random operations with the consumer always ready.
        i_ready = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            i_a     = W'($urandom);
            i_b     = W'($urandom);
            i_valid = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!o_ready && t < 40);
            if (!o_ready) begin
                check("rand_accept_timeout", 32'(o_ready), 32'd1);
                break;
            end
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        t = 0;
        while (q.size() > 0 && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain", 32'(q.size()), 32'd0);
        i_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
